// File: rtl/nop_stream_detector_pkg.sv
// Shared definitions for the NOP stream detector and the reusable NOP classifier:
// rule encodings, FSM states and MIPS field positions.
package nop_det_pkg;

  localparam int NOP_MODE_OPFUNCT = 0;
  localparam int NOP_MODE_ZERO    = 1;
  localparam int NOP_MODE_RD0     = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  // Classify a 32-bit MIPS word under one of the three NOP rules.
  function automatic logic nop_rule(input logic [31:0] word, input int mode);
    logic op_zero;
    logic funct_zero;
    logic rd_zero;
    logic all_zero;
    op_zero    = (word[OP_MSB:OP_LSB] == '0);
    funct_zero = (word[FUNCT_MSB:FUNCT_LSB] == '0);
    rd_zero    = (word[RD_MSB:RD_LSB] == '0);
    all_zero   = (word == '0);
    case (mode)
      NOP_MODE_OPFUNCT: nop_rule = op_zero && funct_zero;
      NOP_MODE_ZERO:    nop_rule = all_zero;
      NOP_MODE_RD0:     nop_rule = op_zero && rd_zero;
      default:          nop_rule = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nop_stream_detector_if.sv
// Bus bundle between the IF/ID register and the NOP stream detector.
// master = pipeline side driving slots, slave = detector.
interface nop_stream_detector_if #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 4,
  parameter int TOT_W   = 16
);
  logic [INSTR_W-1:0] instr_i;
  logic               valid_i;
  logic               stall_i;
  logic               flush_i;
  logic               tot_clr_i;
  logic [INSTR_W-1:0] instr_o;
  logic               valid_o;
  logic               nop_o;
  logic [CNT_W-1:0]   run_len_o;
  logic               burst_o;
  logic [TOT_W-1:0]   nop_total_o;

  modport master (
    output instr_i, valid_i, stall_i, flush_i, tot_clr_i,
    input  instr_o, valid_o, nop_o, run_len_o, burst_o, nop_total_o
  );

  modport slave (
    input  instr_i, valid_i, stall_i, flush_i, tot_clr_i,
    output instr_o, valid_o, nop_o, run_len_o, burst_o, nop_total_o
  );
endinterface

// File: rtl/nop_stream_detector_nop_decode.sv
// Purely combinational MODE-selected NOP classifier; only bits [31:0] are decoded.
// Shared with the EX-stage hazard unit.
module nop_decode
  import nop_det_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int MODE    = NOP_MODE_OPFUNCT
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               is_nop
);

  logic [31:0] word;

  assign word = instr[31:0];

  always_comb begin
    is_nop = nop_rule(word, MODE);
  end

  // Wide instruction buses carry sideband bits the classifier ignores.
  generate
    if (INSTR_W > 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^instr[INSTR_W-1:32];
    end
  endgenerate

endmodule

// File: rtl/nop_stream_detector.sv
// Pipelined NOP stream detector: registers each slot, classifies it and tracks NOP runs.
// Optional saturating total-NOP counter enabled by NOP_STREAM_DETECTOR_PERF_EN.
module nop_stream_detector
  import nop_det_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int MODE     = NOP_MODE_OPFUNCT,
  parameter int BURST_TH = 4,
  parameter int CNT_W    = 4,
  parameter int TOT_W    = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  nop_stream_detector_if.slave bus
);

  generate
    if (INSTR_W < 32 || MODE < 0 || MODE > 2 || CNT_W < 1 || CNT_W > 30 ||
        BURST_TH < 2 || BURST_TH > ((1 << CNT_W) - 1) || TOT_W < 1) begin : g_param_check
      $fatal(1, "nop_stream_detector: illegal parameter set");
    end
  endgenerate

  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TH_VAL  = CNT_W'(BURST_TH);

  logic               dec_nop;
  logic               accept;
  logic [INSTR_W-1:0] instr_reg;
  logic               valid_reg;
  logic               nop_reg;
  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   run_reg;
  logic [CNT_W-1:0]   run_next;
  logic [CNT_W-1:0]   run_inc;

  nop_decode #(
    .INSTR_W(INSTR_W),
    .MODE   (MODE)
  ) u_decode (
    .instr (bus.instr_i),
    .is_nop(dec_nop)
  );

  assign accept = bus.valid_i && !bus.stall_i && !bus.flush_i;

  // Flush beats stall: a killed slot must not linger in the output stage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_reg <= '0;
      valid_reg <= 1'b0;
      nop_reg   <= 1'b0;
    end else if (bus.flush_i) begin
      instr_reg <= '0;
      valid_reg <= 1'b0;
      nop_reg   <= 1'b0;
    end else if (!bus.stall_i) begin
      instr_reg <= bus.instr_i;
      valid_reg <= bus.valid_i;
      nop_reg   <= bus.valid_i && dec_nop;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= S_IDLE;
      run_reg   <= '0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
    end
  end

  assign run_inc = run_reg + CNT_W'(1);

  // Only accepted slots move the FSM; bubbles, stalls and flushes are transparent.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    if (accept) begin
      case (state_reg)
        S_IDLE: begin
          if (dec_nop) begin
            state_next = S_RUN;
            run_next   = CNT_W'(1);
          end
        end
        S_RUN: begin
          if (dec_nop) begin
            run_next = run_inc;
            if (run_inc == TH_VAL) begin
              state_next = S_BURST;
            end
          end else begin
            state_next = S_IDLE;
            run_next   = '0;
          end
        end
        S_BURST: begin
          if (dec_nop) begin
            if (run_reg != RUN_MAX) begin
              run_next = run_inc;
            end
          end else begin
            state_next = S_IDLE;
            run_next   = '0;
          end
        end
        default: begin
          state_next = S_IDLE;
          run_next   = '0;
        end
      endcase
    end
  end

  assign bus.instr_o   = instr_reg;
  assign bus.valid_o   = valid_reg;
  assign bus.nop_o     = nop_reg;
  assign bus.run_len_o = run_reg;
  assign bus.burst_o   = (state_reg == S_BURST);

`ifdef NOP_STREAM_DETECTOR_PERF_EN
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  logic [TOT_W-1:0] tot_reg;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tot_reg <= '0;
    end else if (bus.tot_clr_i) begin
      tot_reg <= '0;
    end else if (accept && dec_nop && tot_reg != TOT_MAX) begin
      tot_reg <= tot_reg + TOT_W'(1);
    end
  end

  assign bus.nop_total_o = tot_reg;
`else
  logic unused_tot_clr;
  assign unused_tot_clr  = bus.tot_clr_i;
  assign bus.nop_total_o = '0;
`endif

endmodule

// File: doc/nop_stream_detector.md
Name: nop_stream_detector

Overview:
- Parametrised, pipelined successor to the single-cycle NOP decoder. Sits between IF/ID and the ID stage of the pipelined MIPS CPU.
- Registers each incoming instruction and classifies it as NOP under a selectable rule.
- Tracks the length of the current run of consecutive NOPs with an FSM and raises a burst flag when the run reaches a threshold.
- Drives the bubble/hazard debug logic and the performance counters.

Parameters:
- INSTR_W, 32, instruction width (≥32; only bits [31:0] are decoded).
- MODE, 0, NOP rule. 0 = opcode==0 && funct==0 (legacy). 1 = all 32 bits zero. 2 = R-type (opcode==0) with rd==0.
- BURST_TH, 4, run length at which burst_o asserts (2..2^CNT_W-1).
- CNT_W, 4, run-length counter width.
- TOT_W, 16, total-NOP counter width (only used with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- instr_i  in  INSTR_W  instruction from IF/ID.
- valid_i  in  1  instr_i carries a real slot.
- stall_i  in  1  hold all state (load-use stall).
- flush_i  in  1  kill the slot in flight (branch taken).
- instr_o  out  INSTR_W  registered instruction.
- valid_o  out  1  registered valid.
- nop_o  out  1  registered NOP classification of instr_o.
- run_len_o  out  CNT_W  consecutive NOPs, including the current one.
- burst_o  out  1  run_len_o ≥ BURST_TH.
- nop_total_o  out  TOT_W  total NOPs accepted (optional feature).
- tot_clr_i  in  1  synchronous clear of nop_total_o (optional feature).

Behaviour:
- Reset (rst_i=0, asynchronous): all outputs are 0 and the FSM is in S_IDLE. Reset mid-run discards the run immediately, without waiting for a clock edge.
- Latency: 1 cycle. An accepted instr_i/valid_i appears on instr_o/valid_o/nop_o at the next rising edge.
- Accept condition: valid_i && !stall_i && !flush_i.
- Priority: flush_i > stall_i > normal.
  - flush_i=1: next cycle valid_o=0, nop_o=0, instr_o=0. Run counter and FSM hold; a flushed slot neither extends nor breaks a run.
  - stall_i=1 (no flush): every register holds, including valid_o.
  - valid_i=0 with no stall/flush: valid_o=0, nop_o=0; run state holds (bubbles are transparent).
- NOP decode: combinational from instr_i under MODE; nop_o = decode && accept, registered.
- FSM (the registered state is the source of burst_o):
  - S_IDLE: run=0. Accepted NOP → S_RUN, run=1. Accepted non-NOP → stay.
  - S_RUN: accepted NOP → run+1, and go to S_BURST when run+1==BURST_TH. Accepted non-NOP → S_IDLE, run=0.
  - S_BURST: accepted NOP → run+1, saturating at 2^CNT_W-1 with no wrap. Accepted non-NOP → S_IDLE, run=0.
- run_len_o is the registered run value. burst_o = (state==S_BURST).
- Width rules: all counters unsigned; the run counter saturates. Parameter values outside the legal ranges are a fatal elaboration check.

Optional Feature:
- Macro: NOP_STREAM_DETECTOR_PERF_EN.
- Defined:
  - nop_total_o increments on every accepted NOP and saturates at 2^TOT_W-1.
  - tot_clr_i clears it synchronously.
  - Same-cycle clear and increment: the result is 0.
  - stall_i blocks the increment. Async reset clears the counter.
- Undefined: nop_total_o is tied to 0, tot_clr_i is ignored, and no counter flops are inferred.

Decomposition:
- Shared package nop_det_pkg:
  - MODE encodings NOP_MODE_OPFUNCT=0, NOP_MODE_ZERO=1, NOP_MODE_RD0=2.
  - FSM state typedef {S_IDLE, S_RUN, S_BURST}, 2-bit.
  - Field slice constants OP_MSB/LSB (31:26), RD_MSB/LSB (15:11), FUNCT_MSB/LSB (5:0).
- One sub-module, nop_decode: purely combinational, MODE-selected classifier. It is reused by the EX-stage hazard unit.

Test Plan:
- Reset: hold rst_i=0 mid-run (run_len_o=3) → all outputs go to 0 asynchronously; after release, FSM is S_IDLE and run_len_o=0.
- MODE=0, BURST_TH=4, stream 5 × 32'h0 then 32'h2002_0001 (addi) → nop_o=1 for 5 cycles; run_len_o 1,2,3,4,5; burst_o first asserts with run_len_o=4; addi gives nop_o=0, run_len_o=0, burst_o=0.
- MODE=1 vs MODE=2 with instr 32'h0000_0040 (sll $0,$0,1):
  - MODE=1 → nop_o=0.
  - MODE=2 → nop_o=1.
  - MODE=0 → nop_o=1.
- Stall/flush: NOP, NOP, then stall_i=1 for 2 cycles → outputs frozen at run_len_o=2. Then flush_i=1 together with stall_i=1 → valid_o=0, run_len_o stays 2. Next NOP → run_len_o=3.
- Saturation: CNT_W=3, 10 consecutive NOPs → run_len_o sticks at 7 and burst_o stays 1.
- NOP_STREAM_DETECTOR_PERF_EN defined, TOT_W=4: 20 NOPs → nop_total_o=15. Then tot_clr_i together with a NOP → 0. With the macro undefined → nop_total_o stays 0 throughout.
